// File: rtl/alu_dispatch_pkg.sv
// alu_dispatch_pkg: shared widths, FSM state encoding and named constants
// for the ALU-class dispatch stage.
package alu_dispatch_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 6;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  localparam logic              VALID     = 1'b1;
  localparam logic              INVALID   = 1'b0;
  localparam logic [DATA_W-1:0] NULL_DATA = '0;
  localparam logic [TAG_W-1:0]  NULL_TAG  = '0;
  localparam logic [OP_W-1:0]   NULL_OP   = '0;

endpackage

// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if: decoder handshake, dispatch push bus toward the ALU RS,
// RS back-pressure and the four CDB broadcast channels.
// slave  = alu_dispatch side, master = surrounding pipeline side.
interface alu_dispatch_if;
  import alu_dispatch_pkg::*;

  // decoder side
  logic              dec_valid;
  logic              dec_ready;
  logic [OP_W-1:0]   dec_op;
  logic [DATA_W-1:0] dec_imm;
  logic [DATA_W-1:0] dec_pc;
  logic              dec_reg1_valid;
  logic [DATA_W-1:0] dec_reg1_data;
  logic [TAG_W-1:0]  dec_reg1_tag;
  logic              dec_reg2_valid;
  logic [DATA_W-1:0] dec_reg2_data;
  logic [TAG_W-1:0]  dec_reg2_tag;
  logic [TAG_W-1:0]  dec_dest_tag;

  // reservation station side
  logic              ALURS_is_full;
  logic              dispatch_valid;
  logic [OP_W-1:0]   dispatch_op;
  logic [DATA_W-1:0] dispatch_imm;
  logic [DATA_W-1:0] dispatch_pc;
  logic              dispatch_reg1_valid;
  logic [DATA_W-1:0] dispatch_reg1_data;
  logic [TAG_W-1:0]  dispatch_reg1_tag;
  logic              dispatch_reg2_valid;
  logic [DATA_W-1:0] dispatch_reg2_data;
  logic [TAG_W-1:0]  dispatch_reg2_tag;
  logic [TAG_W-1:0]  dispatch_reg_dest_tag;

  // common data bus channels
  logic              ALU_cdb_valid;
  logic [TAG_W-1:0]  ALU_cdb_tag;
  logic [DATA_W-1:0] ALU_cdb_data;
  logic              LSB_cdb_valid;
  logic [TAG_W-1:0]  LSB_cdb_tag;
  logic [DATA_W-1:0] LSB_cdb_data;
  logic              Branch_cdb_valid;
  logic [TAG_W-1:0]  Branch_cdb_tag;
  logic [DATA_W-1:0] Branch_cdb_data;
  logic              ROB_cdb_valid;
  logic [TAG_W-1:0]  ROB_cdb_tag;
  logic [DATA_W-1:0] ROB_cdb_data;

  modport slave (
    input  dec_valid, dec_op, dec_imm, dec_pc,
           dec_reg1_valid, dec_reg1_data, dec_reg1_tag,
           dec_reg2_valid, dec_reg2_data, dec_reg2_tag, dec_dest_tag,
           ALURS_is_full,
           ALU_cdb_valid, ALU_cdb_tag, ALU_cdb_data,
           LSB_cdb_valid, LSB_cdb_tag, LSB_cdb_data,
           Branch_cdb_valid, Branch_cdb_tag, Branch_cdb_data,
           ROB_cdb_valid, ROB_cdb_tag, ROB_cdb_data,
    output dec_ready, dispatch_valid, dispatch_op, dispatch_imm, dispatch_pc,
           dispatch_reg1_valid, dispatch_reg1_data, dispatch_reg1_tag,
           dispatch_reg2_valid, dispatch_reg2_data, dispatch_reg2_tag,
           dispatch_reg_dest_tag
  );

  modport master (
    output dec_valid, dec_op, dec_imm, dec_pc,
           dec_reg1_valid, dec_reg1_data, dec_reg1_tag,
           dec_reg2_valid, dec_reg2_data, dec_reg2_tag, dec_dest_tag,
           ALURS_is_full,
           ALU_cdb_valid, ALU_cdb_tag, ALU_cdb_data,
           LSB_cdb_valid, LSB_cdb_tag, LSB_cdb_data,
           Branch_cdb_valid, Branch_cdb_tag, Branch_cdb_data,
           ROB_cdb_valid, ROB_cdb_tag, ROB_cdb_data,
    input  dec_ready, dispatch_valid, dispatch_op, dispatch_imm, dispatch_pc,
           dispatch_reg1_valid, dispatch_reg1_data, dispatch_reg1_tag,
           dispatch_reg2_valid, dispatch_reg2_data, dispatch_reg2_tag,
           dispatch_reg_dest_tag
  );

endinterface

// File: rtl/alu_dispatch_cdb_snoop.sv
// alu_dispatch_cdb_snoop: combinational operand forwarding from the four
// CDB channels. A known operand passes through untouched; an unknown one
// picks up the first matching broadcast in ALU > LSB > Branch > ROB order.
module alu_dispatch_cdb_snoop
  import alu_dispatch_pkg::*;
(
  input  logic              opnd_valid_i,
  input  logic [DATA_W-1:0] opnd_data_i,
  input  logic [TAG_W-1:0]  opnd_tag_i,
  input  logic              alu_valid_i,
  input  logic [TAG_W-1:0]  alu_tag_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              lsb_valid_i,
  input  logic [TAG_W-1:0]  lsb_tag_i,
  input  logic [DATA_W-1:0] lsb_data_i,
  input  logic              br_valid_i,
  input  logic [TAG_W-1:0]  br_tag_i,
  input  logic [DATA_W-1:0] br_data_i,
  input  logic              rob_valid_i,
  input  logic [TAG_W-1:0]  rob_tag_i,
  input  logic [DATA_W-1:0] rob_data_i,
  output logic              opnd_valid_o,
  output logic [DATA_W-1:0] opnd_data_o
);

  // Fixed-priority capture of a matching broadcast for a still-unknown operand.
  always_comb begin
    opnd_valid_o = opnd_valid_i;
    opnd_data_o  = opnd_data_i;
    if (opnd_valid_i == INVALID) begin
      if (alu_valid_i && alu_tag_i == opnd_tag_i) begin
        opnd_valid_o = VALID;
        opnd_data_o  = alu_data_i;
      end else if (lsb_valid_i && lsb_tag_i == opnd_tag_i) begin
        opnd_valid_o = VALID;
        opnd_data_o  = lsb_data_i;
      end else if (br_valid_i && br_tag_i == opnd_tag_i) begin
        opnd_valid_o = VALID;
        opnd_data_o  = br_data_i;
      end else if (rob_valid_i && rob_tag_i == opnd_tag_i) begin
        opnd_valid_o = VALID;
        opnd_data_o  = rob_data_i;
      end
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: one-entry skid buffer between decode/rename and the ALU
// reservation station. Operands are snooped from the CDB at load, every
// held cycle, and combinationally on the outgoing dispatch fields so a
// broadcast in the dispatch cycle is never lost.
// Optional build macro ALU_DISPATCH_PERF_EN adds dispatch/stall counters.
module alu_dispatch
  import alu_dispatch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  alu_dispatch_if.slave     bus
`ifdef ALU_DISPATCH_PERF_EN
  ,
  output logic [31:0]       perf_dispatched,
  output logic [31:0]       perf_full_stall
`endif
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              r1v_q, r1v_d;
  logic [DATA_W-1:0] r1d_q, r1d_d;
  logic [TAG_W-1:0]  r1t_q, r1t_d;
  logic              r2v_q, r2v_d;
  logic [DATA_W-1:0] r2d_q, r2d_d;
  logic [TAG_W-1:0]  r2t_q, r2t_d;
  logic [TAG_W-1:0]  dest_q, dest_d;

  logic              hold_valid;
  logic              fire;
  logic              dec_ready;
  logic              load;
  logic              ld1_v, ld2_v, out1_v, out2_v;
  logic [DATA_W-1:0] ld1_d, ld2_d, out1_d, out2_d;

  assign hold_valid = (state_q == ST_HOLD);
  assign fire       = rdy & ~clear & hold_valid & ~bus.ALURS_is_full;
  assign dec_ready  = rdy & ~clear & (~hold_valid | fire);
  assign load       = bus.dec_valid & dec_ready;

  alu_dispatch_cdb_snoop u_snoop_ld1 (
    .opnd_valid_i(bus.dec_reg1_valid), .opnd_data_i(bus.dec_reg1_data), .opnd_tag_i(bus.dec_reg1_tag),
    .alu_valid_i(bus.ALU_cdb_valid), .alu_tag_i(bus.ALU_cdb_tag), .alu_data_i(bus.ALU_cdb_data),
    .lsb_valid_i(bus.LSB_cdb_valid), .lsb_tag_i(bus.LSB_cdb_tag), .lsb_data_i(bus.LSB_cdb_data),
    .br_valid_i(bus.Branch_cdb_valid), .br_tag_i(bus.Branch_cdb_tag), .br_data_i(bus.Branch_cdb_data),
    .rob_valid_i(bus.ROB_cdb_valid), .rob_tag_i(bus.ROB_cdb_tag), .rob_data_i(bus.ROB_cdb_data),
    .opnd_valid_o(ld1_v), .opnd_data_o(ld1_d)
  );

  alu_dispatch_cdb_snoop u_snoop_ld2 (
    .opnd_valid_i(bus.dec_reg2_valid), .opnd_data_i(bus.dec_reg2_data), .opnd_tag_i(bus.dec_reg2_tag),
    .alu_valid_i(bus.ALU_cdb_valid), .alu_tag_i(bus.ALU_cdb_tag), .alu_data_i(bus.ALU_cdb_data),
    .lsb_valid_i(bus.LSB_cdb_valid), .lsb_tag_i(bus.LSB_cdb_tag), .lsb_data_i(bus.LSB_cdb_data),
    .br_valid_i(bus.Branch_cdb_valid), .br_tag_i(bus.Branch_cdb_tag), .br_data_i(bus.Branch_cdb_data),
    .rob_valid_i(bus.ROB_cdb_valid), .rob_tag_i(bus.ROB_cdb_tag), .rob_data_i(bus.ROB_cdb_data),
    .opnd_valid_o(ld2_v), .opnd_data_o(ld2_d)
  );

  // The output snoop also serves as the held-operand update path.
  alu_dispatch_cdb_snoop u_snoop_out1 (
    .opnd_valid_i(r1v_q), .opnd_data_i(r1d_q), .opnd_tag_i(r1t_q),
    .alu_valid_i(bus.ALU_cdb_valid), .alu_tag_i(bus.ALU_cdb_tag), .alu_data_i(bus.ALU_cdb_data),
    .lsb_valid_i(bus.LSB_cdb_valid), .lsb_tag_i(bus.LSB_cdb_tag), .lsb_data_i(bus.LSB_cdb_data),
    .br_valid_i(bus.Branch_cdb_valid), .br_tag_i(bus.Branch_cdb_tag), .br_data_i(bus.Branch_cdb_data),
    .rob_valid_i(bus.ROB_cdb_valid), .rob_tag_i(bus.ROB_cdb_tag), .rob_data_i(bus.ROB_cdb_data),
    .opnd_valid_o(out1_v), .opnd_data_o(out1_d)
  );

  alu_dispatch_cdb_snoop u_snoop_out2 (
    .opnd_valid_i(r2v_q), .opnd_data_i(r2d_q), .opnd_tag_i(r2t_q),
    .alu_valid_i(bus.ALU_cdb_valid), .alu_tag_i(bus.ALU_cdb_tag), .alu_data_i(bus.ALU_cdb_data),
    .lsb_valid_i(bus.LSB_cdb_valid), .lsb_tag_i(bus.LSB_cdb_tag), .lsb_data_i(bus.LSB_cdb_data),
    .br_valid_i(bus.Branch_cdb_valid), .br_tag_i(bus.Branch_cdb_tag), .br_data_i(bus.Branch_cdb_data),
    .rob_valid_i(bus.ROB_cdb_valid), .rob_tag_i(bus.ROB_cdb_tag), .rob_data_i(bus.ROB_cdb_data),
    .opnd_valid_o(out2_v), .opnd_data_o(out2_d)
  );

  // Next-state: flush beats load beats drain; a held entry keeps snooping.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    r1v_d   = r1v_q;
    r1d_d   = r1d_q;
    r1t_d   = r1t_q;
    r2v_d   = r2v_q;
    r2d_d   = r2d_q;
    r2t_d   = r2t_q;
    dest_d  = dest_q;
    if (rdy) begin
      if (clear) begin
        state_d = ST_EMPTY;
      end else if (load) begin
        state_d = ST_HOLD;
        op_d    = bus.dec_op;
        imm_d   = bus.dec_imm;
        pc_d    = bus.dec_pc;
        r1v_d   = ld1_v;
        r1d_d   = ld1_d;
        r1t_d   = bus.dec_reg1_tag;
        r2v_d   = ld2_v;
        r2d_d   = ld2_d;
        r2t_d   = bus.dec_reg2_tag;
        dest_d  = bus.dec_dest_tag;
      end else if (fire) begin
        state_d = ST_EMPTY;
      end else if (hold_valid) begin
        r1v_d = out1_v;
        r1d_d = out1_d;
        r2v_d = out2_v;
        r2d_d = out2_d;
      end
    end
  end

  // State and hold registers; reset empties the buffer and zeroes every field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      op_q    <= NULL_OP;
      imm_q   <= NULL_DATA;
      pc_q    <= NULL_DATA;
      r1v_q   <= INVALID;
      r1d_q   <= NULL_DATA;
      r1t_q   <= NULL_TAG;
      r2v_q   <= INVALID;
      r2d_q   <= NULL_DATA;
      r2t_q   <= NULL_TAG;
      dest_q  <= NULL_TAG;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      r1v_q   <= r1v_d;
      r1d_q   <= r1d_d;
      r1t_q   <= r1t_d;
      r2v_q   <= r2v_d;
      r2d_q   <= r2d_d;
      r2t_q   <= r2t_d;
      dest_q  <= dest_d;
    end
  end

  // Dispatch fields read as zero whenever nothing is held.
  always_comb begin
    bus.dec_ready             = dec_ready;
    bus.dispatch_valid        = fire;
    bus.dispatch_op           = hold_valid ? op_q   : NULL_OP;
    bus.dispatch_imm          = hold_valid ? imm_q  : NULL_DATA;
    bus.dispatch_pc           = hold_valid ? pc_q   : NULL_DATA;
    bus.dispatch_reg1_valid   = hold_valid ? out1_v : INVALID;
    bus.dispatch_reg1_data    = hold_valid ? out1_d : NULL_DATA;
    bus.dispatch_reg1_tag     = hold_valid ? r1t_q  : NULL_TAG;
    bus.dispatch_reg2_valid   = hold_valid ? out2_v : INVALID;
    bus.dispatch_reg2_data    = hold_valid ? out2_d : NULL_DATA;
    bus.dispatch_reg2_tag     = hold_valid ? r2t_q  : NULL_TAG;
    bus.dispatch_reg_dest_tag = hold_valid ? dest_q : NULL_TAG;
  end

`ifdef ALU_DISPATCH_PERF_EN
  logic [31:0] perf_disp_q, perf_stall_q;

  // Free-running wrap-around counters; only rst clears them, never a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_disp_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (fire)
        perf_disp_q <= perf_disp_q + 32'd1;
      if (rdy & hold_valid & bus.ALURS_is_full & ~clear)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_dispatched = perf_disp_q;
  assign perf_full_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed bench for alu_dispatch (reset, back-to-back
// dispatch, full stall, same-cycle forwarding, CDB priority, flush, rdy freeze).
module tb_alu_dispatch;
  import alu_dispatch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic clear;
  int   checks   = 0;
  int   failures = 0;

  alu_dispatch_if bus ();

`ifdef ALU_DISPATCH_PERF_EN
  logic [31:0] perf_dispatched;
  logic [31:0] perf_full_stall;
`endif

  alu_dispatch dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .clear(clear),
    .bus(bus)
`ifdef ALU_DISPATCH_PERF_EN
    ,
    .perf_dispatched(perf_dispatched),
    .perf_full_stall(perf_full_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [OP_W-1:0] op,
                     input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pc,
                     input logic r1v, input logic [DATA_W-1:0] r1d, input logic [TAG_W-1:0] r1t,
                     input logic r2v, input logic [DATA_W-1:0] r2d, input logic [TAG_W-1:0] r2t,
                     input logic [TAG_W-1:0] dest);
    bus.dec_valid      = v;
    bus.dec_op         = op;
    bus.dec_imm        = imm;
    bus.dec_pc         = pc;
    bus.dec_reg1_valid = r1v;
    bus.dec_reg1_data  = r1d;
    bus.dec_reg1_tag   = r1t;
    bus.dec_reg2_valid = r2v;
    bus.dec_reg2_data  = r2d;
    bus.dec_reg2_tag   = r2t;
    bus.dec_dest_tag   = dest;
  endtask

  task automatic cdb_idle();
    bus.ALU_cdb_valid = 0;    bus.ALU_cdb_tag = 0;    bus.ALU_cdb_data = 0;
    bus.LSB_cdb_valid = 0;    bus.LSB_cdb_tag = 0;    bus.LSB_cdb_data = 0;
    bus.Branch_cdb_valid = 0; bus.Branch_cdb_tag = 0; bus.Branch_cdb_data = 0;
    bus.ROB_cdb_valid = 0;    bus.ROB_cdb_tag = 0;    bus.ROB_cdb_data = 0;
  endtask

  initial begin
    rst = 1; rdy = 1; clear = 0;
    bus.ALURS_is_full = 0;
    dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cdb_idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("reset_dv", bus.dispatch_valid, 0);
    chk("reset_ready", bus.dec_ready, 1);
    chk("reset_op", bus.dispatch_op, 0);

    // back-to-back: three instructions, one per cycle
    tick();
    dec(1, 6'd1, 32'h100, 32'h1000, 1, 32'h10, 4'd1, 1, 32'h20, 4'd2, 4'd1);
    #1;
    chk("b2b_ready0", bus.dec_ready, 1);
    chk("b2b_dv0", bus.dispatch_valid, 0);
    tick();
    dec(1, 6'd2, 32'h200, 32'h1004, 1, 32'h11, 4'd1, 1, 32'h21, 4'd2, 4'd2);
    #1;
    chk("b2b_dv1", bus.dispatch_valid, 1);
    chk("b2b_op1", bus.dispatch_op, 1);
    chk("b2b_r1d1", bus.dispatch_reg1_data, 32'h10);
    chk("b2b_r2d1", bus.dispatch_reg2_data, 32'h20);
    chk("b2b_ready1", bus.dec_ready, 1);
    tick();
    dec(1, 6'd3, 32'h300, 32'h1008, 1, 32'h12, 4'd1, 1, 32'h22, 4'd2, 4'd3);
    #1;
    chk("b2b_dv2", bus.dispatch_valid, 1);
    chk("b2b_op2", bus.dispatch_op, 2);
    chk("b2b_pc2", bus.dispatch_pc, 32'h1004);
    chk("b2b_ready2", bus.dec_ready, 1);
    tick();
    bus.dec_valid = 0;
    #1;
    chk("b2b_dv3", bus.dispatch_valid, 1);
    chk("b2b_op3", bus.dispatch_op, 3);
    chk("b2b_dest3", bus.dispatch_reg_dest_tag, 3);
    tick();
    chk("b2b_empty_dv", bus.dispatch_valid, 0);
    chk("b2b_empty_ready", bus.dec_ready, 1);

    // reset while an instruction is held
    bus.ALURS_is_full = 1;
    dec(1, 6'd7, 32'h77, 32'h2000, 1, 32'h70, 4'd6, 1, 32'h71, 4'd7, 4'd9);
    tick();
    bus.dec_valid = 0;
    #1;
    chk("rsthold_op", bus.dispatch_op, 7);
    chk("rsthold_ready", bus.dec_ready, 0);
    rst = 1;
    #1;
    chk("rst_async_op", bus.dispatch_op, 0);
    tick();
    rst = 0;
    bus.ALURS_is_full = 0;
    #1;
    chk("rst_dv", bus.dispatch_valid, 0);
    chk("rst_ready", bus.dec_ready, 1);
    chk("rst_imm", bus.dispatch_imm, 0);
    chk("rst_pc", bus.dispatch_pc, 0);
    chk("rst_r1d", bus.dispatch_reg1_data, 0);
    chk("rst_dest", bus.dispatch_reg_dest_tag, 0);

    // full stall for four cycles, then one dispatch
    bus.ALURS_is_full = 1;
    dec(1, 6'd4, 32'h44, 32'h3000, 1, 32'h40, 4'd1, 1, 32'h41, 4'd2, 4'd4);
    tick();
    dec(1, 6'd5, 32'h55, 32'h3004, 1, 32'h50, 4'd1, 1, 32'h51, 4'd2, 4'd5);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_dv", bus.dispatch_valid, 0);
      chk("stall_ready", bus.dec_ready, 0);
      chk("stall_op", bus.dispatch_op, 4);
      chk("stall_imm", bus.dispatch_imm, 32'h44);
      tick();
    end
    bus.ALURS_is_full = 0;
    bus.dec_valid = 0;
    #1;
    chk("stall_release_dv", bus.dispatch_valid, 1);
    chk("stall_release_op", bus.dispatch_op, 4);
`ifdef ALU_DISPATCH_PERF_EN
    chk("perf_full_stall", perf_full_stall, 4);
`endif
    tick();
    chk("stall_after_dv", bus.dispatch_valid, 0);
`ifdef ALU_DISPATCH_PERF_EN
    chk("perf_dispatched", perf_dispatched, 1);
    chk("perf_full_stall_end", perf_full_stall, 4);
`endif

    // same-cycle forward from LSB channel
    bus.ALURS_is_full = 1;
    dec(1, 6'd8, 32'h88, 32'h4000, 0, 32'h0, 4'd5, 1, 32'h99, 4'd2, 4'd8);
    tick();
    bus.dec_valid = 0;
    #1;
    chk("fwd_wait_r1v", bus.dispatch_reg1_valid, 0);
    tick();
    bus.ALURS_is_full = 0;
    bus.LSB_cdb_valid = 1; bus.LSB_cdb_tag = 4'd5; bus.LSB_cdb_data = 32'hDEADBEEF;
    #1;
    chk("fwd_dv", bus.dispatch_valid, 1);
    chk("fwd_r1v", bus.dispatch_reg1_valid, 1);
    chk("fwd_r1d", bus.dispatch_reg1_data, 32'hDEADBEEF);
    chk("fwd_r1t", bus.dispatch_reg1_tag, 5);
    chk("fwd_r2d", bus.dispatch_reg2_data, 32'h99);
    tick();
    cdb_idle();

    // priority ALU over ROB; known reg1 untouched even with matching tag
    bus.ALURS_is_full = 1;
    dec(1, 6'd9, 32'h9, 32'h5000, 1, 32'h7, 4'd3, 0, 32'h0, 4'd3, 4'd10);
    tick();
    bus.dec_valid = 0;
    bus.ALU_cdb_valid = 1; bus.ALU_cdb_tag = 4'd3; bus.ALU_cdb_data = 32'h11;
    bus.ROB_cdb_valid = 1; bus.ROB_cdb_tag = 4'd3; bus.ROB_cdb_data = 32'h22;
    #1;
    chk("prio_r2v", bus.dispatch_reg2_valid, 1);
    chk("prio_r2d", bus.dispatch_reg2_data, 32'h11);
    chk("prio_r1d", bus.dispatch_reg1_data, 32'h7);
    tick();
    cdb_idle();
    #1;
    chk("prio_held_r2v", bus.dispatch_reg2_valid, 1);
    chk("prio_held_r2d", bus.dispatch_reg2_data, 32'h11);
    chk("prio_held_r1d", bus.dispatch_reg1_data, 32'h7);
    // tag 0 broadcast must not disturb an already-known operand
    bus.Branch_cdb_valid = 1; bus.Branch_cdb_tag = 4'd0; bus.Branch_cdb_data = 32'hABC;
    bus.ALURS_is_full = 0;
    #1;
    chk("prio_drain_dv", bus.dispatch_valid, 1);
    chk("prio_drain_r2d", bus.dispatch_reg2_data, 32'h11);
    tick();
    cdb_idle();

    // tag 0 capture at load time for both operands
    bus.ALURS_is_full = 1;
    bus.Branch_cdb_valid = 1; bus.Branch_cdb_tag = 4'd0; bus.Branch_cdb_data = 32'h5A5A;
    dec(1, 6'd14, 32'h0, 32'h5800, 0, 32'h0, 4'd0, 0, 32'h0, 4'd0, 4'd11);
    tick();
    cdb_idle();
    bus.dec_valid = 0;
    #1;
    chk("tag0_r1d", bus.dispatch_reg1_data, 32'h5A5A);
    chk("tag0_r2v", bus.dispatch_reg2_valid, 1);
    chk("tag0_r2d", bus.dispatch_reg2_data, 32'h5A5A);

    // flush while held with a competing decoder request
    clear = 1;
    dec(1, 6'd11, 32'hB, 32'h6000, 1, 32'h1, 4'd1, 1, 32'h2, 4'd2, 4'd12);
    bus.ALURS_is_full = 0;
    #1;
    chk("flush_dv", bus.dispatch_valid, 0);
    chk("flush_ready", bus.dec_ready, 0);
    tick();
    clear = 0;
    bus.dec_valid = 0;
    #1;
    chk("flush_empty_dv", bus.dispatch_valid, 0);
    chk("flush_empty_op", bus.dispatch_op, 0);
    chk("flush_empty_ready", bus.dec_ready, 1);

    // rdy low freezes the held entry for two cycles
    bus.ALURS_is_full = 1;
    dec(1, 6'd12, 32'hC, 32'h7000, 1, 32'h3, 4'd1, 1, 32'h4, 4'd2, 4'd13);
    tick();
    rdy = 0;
    bus.ALURS_is_full = 0;
    dec(1, 6'd13, 32'hD, 32'h7004, 1, 32'h5, 4'd1, 1, 32'h6, 4'd2, 4'd14);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("frz_dv", bus.dispatch_valid, 0);
      chk("frz_ready", bus.dec_ready, 0);
      chk("frz_op", bus.dispatch_op, 12);
      tick();
    end
    rdy = 1;
    bus.dec_valid = 0;
    #1;
    chk("frz_release_dv", bus.dispatch_valid, 1);
    chk("frz_release_op", bus.dispatch_op, 12);
    tick();
    chk("frz_final_dv", bus.dispatch_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
